// File: rtl/divider_pkg.sv
// -----------------------------------------------------------------------------
// divider_pkg
// Shared declarations for the iterative radix-2 restoring divider.
//
// Contents:
//   DIV_WIDTH      default operand/result width
//   DIV_CNT_W      iteration-counter width for the default operand width
//   div_state_t    controller state encoding (FIXUP exists only when the
//                  DIVIDER_SIGNED_EN macro is defined)
//   div_cnt_width  counter width for an arbitrary operand width
//
// Configuration macro: DIVIDER_SIGNED_EN (adds the FIXUP state).
// -----------------------------------------------------------------------------
package divider_pkg;

  localparam int DIV_WIDTH = 32;

  // The counter must hold the value WIDTH itself, hence WIDTH+1.
  localparam int DIV_CNT_W = $clog2(DIV_WIDTH + 1);

`ifdef DIVIDER_SIGNED_EN
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    DONE  = 2'd2,
    FIXUP = 2'd3
  } div_state_t;
`else
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } div_state_t;
`endif

  function automatic int div_cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/divider_step.sv
// -----------------------------------------------------------------------------
// divider_step
// One combinational radix-2 restoring division step.
//
// The next dividend bit (MSB of dq) is shifted into the partial remainder.
// If the widened remainder is at least the divisor, the divisor is subtracted
// and a 1 enters the quotient at the LSB of dq; otherwise the remainder is
// kept and a 0 enters the quotient.
//
// Ports:
//   rem       in   WIDTH  partial remainder before the step
//   dq        in   WIDTH  dividend bits still to consume / quotient bits so far
//   b         in   WIDTH  divisor
//   rem_next  out  WIDTH  partial remainder after the step
//   dq_next   out  WIDTH  dq shifted left by one with the new quotient bit
// -----------------------------------------------------------------------------
module divider_step
  import divider_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] dq,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] dq_next
);

  // The shifted remainder needs one extra bit: rem < b can still have its
  // MSB set when b is large, so the shift may carry out of WIDTH bits.
  logic [WIDTH:0]   w_shifted;
  logic             w_ge;
  logic [WIDTH-1:0] w_diff;

  assign w_shifted = {rem, dq[WIDTH-1]};
  assign w_ge      = (w_shifted >= {1'b0, b});

  // When w_ge holds the true difference is below b, so it fits in WIDTH bits
  // and a modular WIDTH-bit subtraction gives the exact result.
  assign w_diff    = w_shifted[WIDTH-1:0] - b;

  assign rem_next  = w_ge ? w_diff : w_shifted[WIDTH-1:0];
  assign dq_next   = {dq[WIDTH-2:0], w_ge};

endmodule

// File: rtl/divider_iterative.sv
// -----------------------------------------------------------------------------
// divider_iterative
// Multi-cycle unsigned integer divider (radix-2 restoring, one quotient bit
// per clock) with valid/ready handshakes on the operand and result sides.
// Computes q = a / b and r = a % b. Division by zero yields q = all ones and
// r = a with the normal latency.
//
// Latency: valid_out rises exactly WIDTH cycles after the accepting edge
// (WIDTH+1 for signed operations when DIVIDER_SIGNED_EN is defined).
// A result can be taken and a new operation accepted in the same cycle.
//
// Ports:
//   clk        in   1      rising-edge clock
//   reset      in   1      synchronous active-high reset
//   valid_in   in   1      a, b valid this cycle
//   ready_in   out  1      divider accepts an operation this cycle
//   a          in   WIDTH  dividend
//   b          in   WIDTH  divisor
//   valid_out  out  1      q, r hold a finished result
//   ready_out  in   1      consumer takes the result this cycle
//   q          out  WIDTH  quotient (registered)
//   r          out  WIDTH  remainder (registered)
//   signed_in  in   1      two's complement operation, sampled on accept
//                          (present only with DIVIDER_SIGNED_EN)
//
// Configuration macro: DIVIDER_SIGNED_EN
//   Defined:   signed_in port and a one-cycle FIXUP state that applies the
//              result signs after an unsigned divide of the magnitudes.
//   Undefined: unsigned only.
// -----------------------------------------------------------------------------
module divider_iterative
  import divider_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_in,
  output logic             ready_in,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             valid_out,
  input  logic             ready_out,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r
`ifdef DIVIDER_SIGNED_EN
  ,
  input  logic             signed_in
`endif
);

  localparam int CNT_W = div_cnt_width(WIDTH);

  div_state_t       r_state;
  div_state_t       w_state_next;

  logic [WIDTH-1:0] r_dq;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_b;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_r;

  logic [WIDTH-1:0] w_rem_next;
  logic [WIDTH-1:0] w_dq_next;
  logic [WIDTH-1:0] w_a_load;
  logic [WIDTH-1:0] w_b_load;
  logic             w_accept;
  logic             w_take;
  logic             w_last;
  logic             w_fixup_needed;

  assign w_accept = valid_in && ready_in;
  assign w_take   = valid_out && ready_out;
  assign w_last   = (r_cnt == CNT_W'(1));

`ifdef DIVIDER_SIGNED_EN
  logic r_signed_op;
  logic r_neg_q;
  logic r_neg_r;

  // Signed operations divide magnitudes. MIN has no positive counterpart,
  // but its unsigned bit pattern is already the correct magnitude.
  assign w_a_load       = (signed_in && a[WIDTH-1]) ? -a : a;
  assign w_b_load       = (signed_in && b[WIDTH-1]) ? -b : b;
  assign w_fixup_needed = r_signed_op;
`else
  assign w_a_load       = a;
  assign w_b_load       = b;
  assign w_fixup_needed = 1'b0;
`endif

  // Single step instance, fed from the working registers every BUSY cycle.
  divider_step #(
    .WIDTH   (WIDTH)
  ) u_step (
    .rem      (r_rem),
    .dq       (r_dq),
    .b        (r_b),
    .rem_next (w_rem_next),
    .dq_next  (w_dq_next)
  );

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_next = BUSY;
        end
      end
      BUSY: begin
        if (w_last) begin
`ifdef DIVIDER_SIGNED_EN
          w_state_next = w_fixup_needed ? FIXUP : DONE;
`else
          w_state_next = DONE;
`endif
        end
      end
`ifdef DIVIDER_SIGNED_EN
      FIXUP: begin
        w_state_next = DONE;
      end
`endif
      DONE: begin
        // ready_in is high whenever a take happens here, so an accompanying
        // valid_in starts the next operation with no idle cycle between.
        if (w_take) begin
          w_state_next = w_accept ? BUSY : IDLE;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs (ready_in deliberately ignores valid_in)
  // ---------------------------------------------------------------------------
  always_comb begin
    ready_in  = 1'b0;
    valid_out = 1'b0;
    case (r_state)
      IDLE: ready_in = 1'b1;
      DONE: begin
        ready_in  = ready_out;
        valid_out = 1'b1;
      end
      default: begin
        ready_in  = 1'b0;
        valid_out = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath. Accepts only occur in IDLE or DONE, so they never collide with
  // an iteration step. q and r change only when a result completes (or on
  // reset), so a partially computed result is never visible.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_dq  <= '0;
      r_rem <= '0;
      r_b   <= '0;
      r_cnt <= '0;
      r_q   <= '0;
      r_r   <= '0;
`ifdef DIVIDER_SIGNED_EN
      r_signed_op <= 1'b0;
      r_neg_q     <= 1'b0;
      r_neg_r     <= 1'b0;
`endif
    end else if (w_accept) begin
      r_dq  <= w_a_load;
      r_b   <= w_b_load;
      r_rem <= '0;
      r_cnt <= CNT_W'(WIDTH);
`ifdef DIVIDER_SIGNED_EN
      r_signed_op <= signed_in;
      // A zero divisor keeps the all-ones quotient, so its sign is not
      // applied. The remainder follows the dividend's sign, which makes
      // r = a for a zero divisor as well.
      r_neg_q     <= signed_in && (a[WIDTH-1] != b[WIDTH-1]) && (b != '0);
      r_neg_r     <= signed_in && a[WIDTH-1];
`endif
    end else if (r_state == BUSY) begin
      r_dq  <= w_dq_next;
      r_rem <= w_rem_next;
      r_cnt <= r_cnt - CNT_W'(1);
      if (w_last && !w_fixup_needed) begin
        r_q <= w_dq_next;
        r_r <= w_rem_next;
      end
    end
`ifdef DIVIDER_SIGNED_EN
    else if (r_state == FIXUP) begin
      r_q <= r_neg_q ? -r_dq  : r_dq;
      r_r <= r_neg_r ? -r_rem : r_rem;
    end
`endif
  end

  assign q = r_q;
  assign r = r_r;

endmodule
